// File: rtl/alu_op_sequencer_if.sv
// rtl/alu_op_sequencer_if.sv - request/result bundle between instruction decode and the ALU sequencer
interface alu_op_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_m;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_wb;

    modport master (
        output req_valid, req_op, req_a, req_m,
        input  req_ready, res_valid, res_data, res_wb
    );

    modport slave (
        input  req_valid, req_op, req_a, req_m,
        output req_ready, res_valid, res_data, res_wb
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - sequences one 6502 ALU micro-op at a time and owns status register P
module alu_op_sequencer #(
    parameter logic [2:0] ALU_ADD = 3'd0,
    parameter logic [2:0] ALU_AND = 3'd1,
    parameter logic [7:0] P_RESET = 8'h24
) (
    input  logic                      clk,
    input  logic                      reset,
    alu_op_sequencer_if.slave         req,
    input  logic                      p_wr,
    input  logic [7:0]                p_wdata,
    output logic [7:0]                p_out,
    output logic                      busy,
    output logic [2:0]                alu_ctrl,
    output logic [7:0]                alu_AI,
    output logic [7:0]                alu_BI,
    output logic                      alu_carry,
    output logic                      alu_BCD,
    input  logic [7:0]                alu_Y,
    input  logic [7:0]                alu_flags
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SETUP   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [3:0] OP_ADC = 4'd0;
    localparam logic [3:0] OP_SBC = 4'd1;
    localparam logic [3:0] OP_CMP = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_INC = 4'd4;
    localparam logic [3:0] OP_DEC = 4'd5;
    localparam logic [3:0] OP_ASL = 4'd6;
    localparam logic [3:0] OP_ROL = 4'd7;

    logic [1:0] state;
    logic [3:0] op_reg;
    logic [7:0] a_reg;
    logic [7:0] m_reg;
    logic [7:0] y_reg;
    logic [7:0] p_reg;
    logic [7:0] p_next;
    logic       op_valid;
    logic       accept;
    logic       unused_flags;

    // Only the carry bit of the ALU flag bus is meaningful here.
    assign unused_flags = ^alu_flags[7:1];

    assign p_out         = p_reg;
    assign busy          = (state != S_IDLE);
    assign op_valid      = !op_reg[3];
    assign req.req_ready = (state == S_IDLE) && !p_wr && !reset;
    assign accept        = req.req_valid && req.req_ready;

    // Flag update from the live ALU output during CAPTURE; V uses the registered ALU inputs.
    always_comb begin
        logic n_f, z_f, c_f, v_f;
        n_f    = alu_Y[7];
        z_f    = (alu_Y == 8'h00);
        c_f    = alu_flags[0];
        v_f    = (alu_AI[7] == alu_BI[7]) && (alu_Y[7] != alu_AI[7]);
        p_next = p_reg;
        case (op_reg)
            OP_ADC, OP_SBC: begin
                p_next[7] = n_f;
                p_next[6] = v_f;
                p_next[1] = z_f;
                p_next[0] = c_f;
            end
            OP_CMP, OP_ASL, OP_ROL: begin
                p_next[7] = n_f;
                p_next[1] = z_f;
                p_next[0] = c_f;
            end
            OP_AND, OP_INC, OP_DEC: begin
                p_next[7] = n_f;
                p_next[1] = z_f;
            end
            default: p_next = p_reg;
        endcase
        p_next[5] = 1'b1;
    end

    // Four-state sequencer: accept, program ALU, capture and commit flags, present result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            p_reg         <= P_RESET;
            op_reg        <= 4'd0;
            a_reg         <= 8'h00;
            m_reg         <= 8'h00;
            y_reg         <= 8'h00;
            req.res_valid <= 1'b0;
            req.res_data  <= 8'h00;
            req.res_wb    <= 1'b0;
            alu_ctrl      <= ALU_ADD;
            alu_AI        <= 8'h00;
            alu_BI        <= 8'h00;
            alu_carry     <= 1'b0;
            alu_BCD       <= 1'b0;
        end else begin
            req.res_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (p_wr) begin
                        p_reg <= p_wdata | 8'h20;
                    end else if (accept) begin
                        op_reg <= req.req_op;
                        a_reg  <= req.req_a;
                        m_reg  <= req.req_m;
                        state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    alu_ctrl  <= ALU_ADD;
                    alu_BCD   <= 1'b0;
                    alu_carry <= 1'b0;
                    alu_AI    <= 8'h00;
                    alu_BI    <= 8'h00;
                    case (op_reg)
                        OP_ADC: begin
                            alu_AI <= a_reg;  alu_BI <= m_reg;
                            alu_carry <= p_reg[0]; alu_BCD <= p_reg[3];
                        end
                        OP_SBC: begin
                            alu_AI <= a_reg;  alu_BI <= ~m_reg;
                            alu_carry <= p_reg[0]; alu_BCD <= p_reg[3];
                        end
                        OP_CMP: begin
                            alu_AI <= a_reg;  alu_BI <= ~m_reg; alu_carry <= 1'b1;
                        end
                        OP_AND: begin
                            alu_ctrl <= ALU_AND; alu_AI <= a_reg; alu_BI <= m_reg;
                        end
                        OP_INC: begin
                            alu_AI <= m_reg;  alu_BI <= 8'h00; alu_carry <= 1'b1;
                        end
                        OP_DEC: begin
                            alu_AI <= m_reg;  alu_BI <= 8'hFF;
                        end
                        OP_ASL: begin
                            alu_AI <= a_reg;  alu_BI <= a_reg;
                        end
                        OP_ROL: begin
                            alu_AI <= a_reg;  alu_BI <= a_reg; alu_carry <= p_reg[0];
                        end
                        default: ;
                    endcase
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    y_reg <= alu_Y;
                    p_reg <= p_next;
                    state <= S_DONE;
                end
                default: begin
                    req.res_valid <= 1'b1;
                    req.res_data  <= op_valid ? y_reg : 8'h00;
                    req.res_wb    <= op_valid && (op_reg != OP_CMP);
                    state         <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       p_wr;
    logic [7:0] p_wdata;
    logic [7:0] p_out;
    logic       busy;
    logic [2:0] alu_ctrl;
    logic [7:0] alu_AI;
    logic [7:0] alu_BI;
    logic       alu_carry;
    logic       alu_BCD;
    logic [7:0] alu_Y;
    logic [7:0] alu_flags;
    logic       alu_c;

    int total = 0;
    int bad   = 0;

    alu_op_sequencer_if bus ();

    alu_op_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .req       (bus),
        .p_wr      (p_wr),
        .p_wdata   (p_wdata),
        .p_out     (p_out),
        .busy      (busy),
        .alu_ctrl  (alu_ctrl),
        .alu_AI    (alu_AI),
        .alu_BI    (alu_BI),
        .alu_carry (alu_carry),
        .alu_BCD   (alu_BCD),
        .alu_Y     (alu_Y),
        .alu_flags (alu_flags)
    );

    always #5 clk = ~clk;

    // Simple ALU stand-in: binary add with carry, or AND.
    always_comb begin
        logic [8:0] sum;
        sum = {1'b0, alu_AI} + {1'b0, alu_BI} + {8'h00, alu_carry};
        if (alu_ctrl == 3'd1) begin
            alu_Y = alu_AI & alu_BI;
            alu_c = 1'b0;
        end else begin
            alu_Y = sum[7:0];
            alu_c = sum[8];
        end
        alu_flags = {7'b0, alu_c};
    end

    task automatic load_p(input logic [7:0] v);
        @(negedge clk);
        p_wr = 1'b1; p_wdata = v;
        @(posedge clk);
        #1 p_wr = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] m,
                          output logic [7:0] data, output logic wb, output int lat);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_m = m;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 99; data = 8'h00; wb = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                lat = i; data = bus.res_data; wb = bus.res_wb;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; p_wr = 1'b0; p_wdata = 8'h00;
        bus.req_valid = 1'b0; bus.req_op = 4'd0; bus.req_a = 8'h00; bus.req_m = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (p_out !== 8'h24) begin bad++; $display("FAIL reset_p got=%h exp=24", p_out); end
        total++; if (bus.res_valid !== 1'b0 || bus.res_data !== 8'h00 || bus.res_wb !== 1'b0) begin
            bad++; $display("FAIL reset_res got=%b/%h/%b exp=0/00/0", bus.res_valid, bus.res_data, bus.res_wb); end
        total++; if (busy !== 1'b0 || bus.req_ready !== 1'b0) begin
            bad++; $display("FAIL reset_busy_ready got=%b/%b exp=0/0", busy, bus.req_ready); end
        total++; if ({alu_ctrl, alu_AI, alu_BI, alu_carry, alu_BCD} !== 21'd0) begin
            bad++; $display("FAIL reset_alu got=%h/%h/%h/%b/%b exp=0", alu_ctrl, alu_AI, alu_BI, alu_carry, alu_BCD); end
        reset = 1'b0;
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b exp=1", bus.req_ready); end
    endtask

    task automatic test_adc();
        logic [7:0] d; logic wb; int lat;
        run_op(4'd0, 8'h50, 8'h50, d, wb, lat);
        total++; if (lat !== 3) begin bad++; $display("FAIL adc_latency got=%0d exp=3", lat); end
        total++; if (d !== 8'hA0 || wb !== 1'b1) begin bad++; $display("FAIL adc_res got=%h/%b exp=a0/1", d, wb); end
        total++; if (p_out !== 8'hE4) begin bad++; $display("FAIL adc_p got=%h exp=e4", p_out); end
        @(negedge clk);
        total++; if (bus.res_valid !== 1'b0 || bus.res_data !== 8'hA0) begin
            bad++; $display("FAIL adc_pulse got=%b/%h exp=0/a0", bus.res_valid, bus.res_data); end
    endtask

    task automatic test_sbc();
        logic [7:0] d; logic wb; int lat;
        load_p(8'h01);
        @(negedge clk);
        total++; if (p_out !== 8'h21) begin bad++; $display("FAIL pwr_load got=%h exp=21", p_out); end
        run_op(4'd1, 8'h00, 8'h01, d, wb, lat);
        total++; if (lat !== 3 || d !== 8'hFF || wb !== 1'b1) begin
            bad++; $display("FAIL sbc_res got=%0d/%h/%b exp=3/ff/1", lat, d, wb); end
        total++; if (p_out !== 8'hA0) begin bad++; $display("FAIL sbc_p got=%h exp=a0", p_out); end
    endtask

    task automatic test_cmp();
        logic [7:0] d; logic wb; int lat;
        load_p(8'h40);
        run_op(4'd2, 8'h40, 8'h40, d, wb, lat);
        total++; if (lat !== 3 || d !== 8'h00 || wb !== 1'b0) begin
            bad++; $display("FAIL cmp_eq_res got=%0d/%h/%b exp=3/00/0", lat, d, wb); end
        total++; if (p_out !== 8'h63) begin bad++; $display("FAIL cmp_eq_p got=%h exp=63", p_out); end
        run_op(4'd2, 8'h10, 8'h20, d, wb, lat);
        total++; if (d !== 8'hF0 || wb !== 1'b0) begin bad++; $display("FAIL cmp_lt_res got=%h/%b exp=f0/0", d, wb); end
        total++; if (p_out !== 8'hE0) begin bad++; $display("FAIL cmp_lt_p got=%h exp=e0", p_out); end
    endtask

    task automatic test_inc_rol();
        logic [7:0] d; logic wb; int lat;
        load_p(8'h01);
        run_op(4'd4, 8'h00, 8'hFF, d, wb, lat);
        total++; if (d !== 8'h00 || wb !== 1'b1) begin bad++; $display("FAIL inc_res got=%h/%b exp=00/1", d, wb); end
        total++; if (p_out !== 8'h23) begin bad++; $display("FAIL inc_p got=%h exp=23", p_out); end
        run_op(4'd7, 8'h80, 8'h00, d, wb, lat);
        total++; if (d !== 8'h01 || wb !== 1'b1) begin bad++; $display("FAIL rol_res got=%h/%b exp=01/1", d, wb); end
        total++; if (p_out !== 8'h21) begin bad++; $display("FAIL rol_p got=%h exp=21", p_out); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ops [4] = '{4'd3, 4'd9, 4'd5, 4'd6};
        logic [7:0] as  [4] = '{8'hF0, 8'h55, 8'h00, 8'h81};
        logic [7:0] ms  [4] = '{8'h3C, 8'h55, 8'h00, 8'h00};
        logic [7:0] eds [4] = '{8'h30, 8'h00, 8'hFF, 8'h02};
        logic       ewb [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic [7:0] eps [4] = '{8'h21, 8'h21, 8'hA1, 8'h21};
        logic [7:0] d; logic wb; int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], ms[i], d, wb, lat);
            total++;
            if (lat !== 3 || d !== eds[i] || wb !== ewb[i] || p_out !== eps[i]) begin
                bad++;
                $display("FAIL b2b_%0d got=%0d/%h/%b/%h exp=3/%h/%b/%h", i, lat, d, wb, p_out, eds[i], ewb[i], eps[i]);
            end
        end
    endtask

    task automatic test_pwr_priority();
        @(negedge clk);
        p_wr = 1'b1; p_wdata = 8'h81;
        bus.req_valid = 1'b1; bus.req_op = 4'd0; bus.req_a = 8'h01; bus.req_m = 8'h01;
        #1;
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL prio_ready got=%b exp=0", bus.req_ready); end
        @(posedge clk);
        #1 p_wr = 1'b0; bus.req_valid = 1'b0;
        @(negedge clk);
        total++; if (p_out !== 8'hA1 || busy !== 1'b0) begin
            bad++; $display("FAIL prio_p got=%h/%b exp=a1/0", p_out, busy); end
    endtask

    task automatic test_pwr_busy();
        int lat;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 4'd3; bus.req_a = 8'h0F; bus.req_m = 8'hF0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0; p_wr = 1'b1; p_wdata = 8'hFF;
        @(negedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy_flag got=%b exp=1", busy); end
        @(posedge clk);
        #1 p_wr = 1'b0;
        lat = 99;
        for (int i = 1; i < 20; i++) begin
            @(negedge clk);
            if (bus.res_valid) begin lat = i; break; end
        end
        total++; if (lat !== 3 || p_out !== 8'h23 || bus.res_data !== 8'h00) begin
            bad++; $display("FAIL pwr_busy got=%0d/%h/%h exp=3/23/00", lat, p_out, bus.res_data); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = 4'd0; bus.req_a = 8'h50; bus.req_m = 8'h50;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.res_valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL abort_valid got=%0d exp=0", seen); end
        total++; if (p_out !== 8'h24 || busy !== 1'b0) begin
            bad++; $display("FAIL abort_p got=%h/%b exp=24/0", p_out, busy); end
    endtask

    initial begin
        test_reset();
        test_adc();
        test_sbc();
        test_cmp();
        test_inc_rol();
        test_back_to_back();
        test_pwr_priority();
        test_pwr_busy();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle controller that sequences the 6502 ALU for one arithmetic/logic micro-operation at a time and owns the processor status register P.
- Accepts operation requests over a valid/ready handshake, maps each opcode onto the ALU's ADD/AND primitives, and drives the ALU inputs from registers.
- Captures the ALU output, computes and commits N/V/Z/C into P, and presents the result with a one-cycle valid pulse.
- Sits between instruction decode and the ALU.

Parameters:
- ALU_ADD, 3'd0, alu_ctrl encoding for binary add with carry-in.
- ALU_AND, 3'd1, alu_ctrl encoding for bitwise AND.
- P_RESET, 8'h24, reset value of the status register (I=1, bit5=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  operation request.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_op  in  4  0 ADC, 1 SBC, 2 CMP, 3 AND, 4 INC, 5 DEC, 6 ASL, 7 ROL, 8-15 invalid.
- req_a  in  8  accumulator/register operand.
- req_m  in  8  memory operand.
- p_wr  in  1  direct status-register load request.
- p_wdata  in  8  data for the direct load.
- p_out  out  8  current status register.
- res_valid  out  1  one-cycle result strobe.
- res_data  out  8  operation result, held until the next result.
- res_wb  out  1  result must be written back; valid with res_valid.
- busy  out  1  FSM not in IDLE.
- alu_ctrl  out  3  to ALU.
- alu_AI  out  8  to ALU.
- alu_BI  out  8  to ALU.
- alu_carry  out  1  to ALU.
- alu_BCD  out  1  to ALU.
- alu_Y  in  8  ALU result.
- alu_flags  in  8  ALU flags; only bit 0 (carry) is consumed.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high, on port `reset`.
- Reset values:
  - FSM goes to IDLE.
  - p_out=P_RESET, res_valid=0, res_data=0, res_wb=0, busy=0, req_ready=0.
  - alu_ctrl=ALU_ADD, alu_AI=alu_BI=0, alu_carry=0, alu_BCD=0.
- Reset mid-operation: the operation is aborted, no flag commit, no res_valid.
- P bit map: C=0, Z=1, I=2, D=3, B=4, bit5 always reads 1, V=6, N=7.
- FSM states: IDLE -> SETUP -> CAPTURE -> DONE -> IDLE, one cycle each.
- IDLE:
  - req_ready = !p_wr.
  - p_wr in IDLE loads P <= p_wdata | 8'h20.
  - p_wr has priority over a simultaneous request; that request is not accepted and must be held.
  - p_wr outside IDLE is ignored.
- SETUP: latches the ALU input registers from the accepted operands:
  - ADC: ADD, AI=A, BI=M, carry=P.C, BCD=P.D.
  - SBC: ADD, AI=A, BI=~M, carry=P.C, BCD=P.D.
  - CMP: ADD, AI=A, BI=~M, carry=1, BCD=0.
  - AND: AND, AI=A, BI=M.
  - INC: ADD, AI=M, BI=0, carry=1.
  - DEC: ADD, AI=M, BI=FF, carry=0.
  - ASL: ADD, AI=A, BI=A, carry=0.
  - ROL: ADD, AI=A, BI=A, carry=P.C.
  - BCD=0 for all ops except ADC/SBC.
- CAPTURE: samples alu_Y and alu_flags[0]; flags computed here are committed to P at the end of the cycle.
  - Z = (Y==0); N = Y[7].
  - V = (AI[7]==BI[7]) && (Y[7]!=AI[7]), using the registered AI/BI.
  - Flags affected per op:
    - ADC/SBC: N V Z C.
    - CMP/ASL/ROL: N Z C.
    - AND/INC/DEC: N Z.
  - Bits not listed are unchanged.
  - Invalid op: no flag change.
- DONE:
  - res_valid=1 for exactly this cycle; res_data=captured Y.
  - res_wb=1 except for CMP and invalid ops, which give res_wb=0.
  - Invalid ops give res_data=0.
- Latency: handshake at edge N -> res_valid high in the cycle after edge N+3. Back-to-back throughput is 1 op per 4 cycles.
- BCD: BCD correction is out of scope; alu_BCD is only forwarded.

Test Plan:
- Reset, then ADC with P.C=0, A=50, M=50 -> res_data=A0, res_wb=1, N=1, V=1, Z=0, C=0; res_valid 4 cycles after the handshake.
- p_wr p_wdata=01 (C=1), then SBC A=00, M=01 -> res_data=FF, C=0, N=1, Z=0, V=0.
- CMP A=40, M=40 -> Z=1, C=1, N=0, res_wb=0, V unchanged. Then CMP A=10, M=20 -> C=0, N=1.
- P.C=1, INC M=FF -> res_data=00, Z=1, C still 1. Then ROL A=80 with C=1 -> res_data=01, C=1, N=0.
- req_valid and p_wr asserted together in IDLE -> req_ready=0 and P loaded. Then p_wr during busy -> ignored. Then reset asserted in CAPTURE -> no res_valid and p_out=24.
